// File: rtl/sipo_stream_pkg.sv
// Shared types and helpers for the sipo_stream deserialiser.
// Holds the FSM state encoding, the bit-counter width rule and the even-parity helper.
package sipo_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } sipo_state_e;

    // Widest word the parity helper covers; narrower words are zero-extended by the caller.
    localparam int PARITY_MAX_W = 64;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sipo_stream_if.sv
// Serial input and word-handshake bundle for sipo_stream.
// master is the deserialiser's view; slave is the producer/consumer view.
interface sipo_stream_if #(
    parameter int WIDTH = 8
);
    logic             data_in;
    logic             enable;
    logic             set_all_ones;
    logic             out_ready;
    logic [WIDTH-1:0] shift_out;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             overrun;
    logic             parity_err;

    modport master (
        input  data_in, enable, set_all_ones, out_ready,
        output shift_out, out_data, out_valid, overrun, parity_err
    );

    modport slave (
        output data_in, enable, set_all_ones, out_ready,
        input  shift_out, out_data, out_valid, overrun, parity_err
    );
endinterface

// File: rtl/sipo_bit_counter.sv
// Counts accepted data bits 0..WIDTH-1 and pulses wrap on the WIDTH-th bit.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic wrap
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // wrap is combinational so the word completes on the same edge as its last bit
    always_comb begin
        wrap    = enable && !clear && (count_q == LAST);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = wrap ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/sipo_stream.sv
// Serial-in/parallel-out deserialiser with a one-entry valid/ready holding register.
// Define SIPO_PARITY_EN to expect an even-parity bit after every WIDTH data bits.
module sipo_stream
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    sipo_stream_if.master bus
);
    logic [WIDTH-1:0] shift_q, shift_d, shifted;
    logic [WIDTH-1:0] hold_q, hold_d, new_word;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             complete, collecting, cnt_en, wrap;

`ifdef SIPO_PARITY_EN
    localparam logic [0:0] ST_COLLECT = COLLECT;
    localparam logic [0:0] ST_PARITY  = PARITY;

    logic [0:0] state_q, state_d;
    logic       perr_q, perr_d, new_perr;

    assign collecting = (state_q == ST_COLLECT);
`else
    assign collecting = 1'b1;
`endif

    // The parity bit is not a data bit, so the counter only advances while collecting
    assign cnt_en = bus.enable && !bus.set_all_ones && collecting;

    sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus.set_all_ones),
        .enable (cnt_en),
        .wrap   (wrap)
    );

    always_comb begin
        if (LSB_FIRST) shifted = {bus.data_in, shift_q[WIDTH-1:1]};
        else           shifted = {shift_q[WIDTH-2:0], bus.data_in};
    end

    always_comb begin
        shift_d  = shift_q;
        hold_d   = hold_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        complete = 1'b0;
        new_word = shifted;
`ifdef SIPO_PARITY_EN
        state_d  = state_q;
        perr_d   = perr_q;
        new_perr = 1'b0;
`endif

        if (bus.set_all_ones) begin
            shift_d = '1;
`ifdef SIPO_PARITY_EN
            state_d = ST_COLLECT;
`endif
        end else if (bus.enable) begin
`ifdef SIPO_PARITY_EN
            if (state_q == ST_PARITY) begin
                complete = 1'b1;
                new_word = shift_q;
                new_perr = even_parity(PARITY_MAX_W'(shift_q)) ^ bus.data_in;
                state_d  = ST_COLLECT;
            end else begin
                shift_d = shifted;
                if (wrap) state_d = ST_PARITY;
            end
`else
            shift_d  = shifted;
            complete = wrap;
`endif
        end

        // A consumer taking the old word on this edge frees the slot for the new one
        if (complete) begin
            if (!valid_q || bus.out_ready) begin
                hold_d  = new_word;
                valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                perr_d  = new_perr;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
            state_q <= ST_COLLECT;
            perr_q  <= 1'b0;
`endif
        end else begin
            shift_q <= shift_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef SIPO_PARITY_EN
            state_q <= state_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.shift_out = shift_q;
    assign bus.out_data  = hold_q;
    assign bus.out_valid = valid_q;
    assign bus.overrun   = ovr_q;
`ifdef SIPO_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sipo_stream.sv
// Bench for sipo_stream: one MSB-first and one LSB-first instance (WIDTH=4) share the stimulus.
module tb_sipo_stream;
`ifdef SIPO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, data_in, enable, set_all_ones, out_ready;

    always #5 clk = ~clk;

    sipo_stream_if #(.WIDTH(4)) bus0 ();
    sipo_stream_if #(.WIDTH(4)) bus1 ();

    assign bus0.data_in = data_in;      assign bus1.data_in = data_in;
    assign bus0.enable = enable;        assign bus1.enable = enable;
    assign bus0.set_all_ones = set_all_ones; assign bus1.set_all_ones = set_all_ones;
    assign bus0.out_ready = out_ready;  assign bus1.out_ready = out_ready;

    sipo_stream #(.WIDTH(4), .LSB_FIRST(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    sipo_stream #(.WIDTH(4), .LSB_FIRST(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] w0;
        logic [3:0] w1;
        logic       perr;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        string      name;
        logic [3:0] bits;
        logic       par;
        logic [3:0] exp_msb;
        logic [3:0] exp_lsb;
        logic       exp_perr;
    } vec_t;
    vec_t vecs[6];

    // Reference model state
    logic [3:0] m_sh0, m_sh1;
    int         m_cnt;
    bit         m_par, m_valid, m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic       cons, complete, np;
        logic [3:0] d0, d1, nw0, nw1;
        logic       pe0, pe1;
        exp_t       e;
        cons = bus0.out_valid && out_ready && !reset;
        d0 = bus0.out_data;  d1 = bus1.out_data;
        pe0 = bus0.parity_err; pe1 = bus1.parity_err;
        complete = 1'b0; nw0 = '0; nw1 = '0; np = 1'b0;
        if (reset) begin
            cons = 1'b0;
            m_sh0 = '0; m_sh1 = '0; m_cnt = 0; m_par = 0; m_valid = 0; m_ovr = 0;
            sbq.delete();
        end else begin
            if (set_all_ones) begin
                m_sh0 = '1; m_sh1 = '1; m_cnt = 0; m_par = 0;
            end else if (enable) begin
                if (m_par) begin
                    complete = 1'b1; nw0 = m_sh0; nw1 = m_sh1;
                    np = (^m_sh0) ^ data_in; m_par = 0;
                end else begin
                    m_sh0 = {m_sh0[2:0], data_in};
                    m_sh1 = {data_in, m_sh1[3:1]};
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_cnt = 0;
                        if (PAR_EN) m_par = 1;
                        else begin complete = 1'b1; nw0 = m_sh0; nw1 = m_sh1; end
                    end
                end
            end
            if (complete) begin
                if (!m_valid || out_ready) begin
                    sbq.push_back('{nw0, nw1, np});
                    m_valid = 1;
                end else m_ovr = 1;
            end else if (m_valid && out_ready) m_valid = 0;
        end
        @(posedge clk);
        #1;
        if (cons) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underflow: consumed %0h with nothing expected", d0);
            end else begin
                e = sbq.pop_front();
                check("sb_data_msb", 32'(d0), 32'(e.w0));
                check("sb_data_lsb", 32'(d1), 32'(e.w1));
                check("sb_perr_msb", 32'(pe0), 32'(e.perr));
                check("sb_perr_lsb", 32'(pe1), 32'(e.perr));
            end
        end
        check("shift_msb", 32'(bus0.shift_out), 32'(m_sh0));
        check("shift_lsb", 32'(bus1.shift_out), 32'(m_sh1));
        check("valid_msb", 32'(bus0.out_valid), 32'(m_valid));
        check("valid_lsb", 32'(bus1.out_valid), 32'(m_valid));
        check("overrun_msb", 32'(bus0.overrun), 32'(m_ovr));
        check("overrun_lsb", 32'(bus1.overrun), 32'(m_ovr));
    endtask

    task automatic send_bits(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) begin
            data_in = bits[i]; enable = 1'b1; tick();
        end
        enable = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] bits, input logic par);
        send_bits(bits);
        if (PAR_EN) begin
            data_in = par; enable = 1'b1; tick();
            enable = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{"w1011_p1", 4'b1011, 1'b1, 4'b1011, 4'b1101, 1'b0};
        vecs[1] = '{"w1011_p0", 4'b1011, 1'b0, 4'b1011, 4'b1101, 1'b1};
        vecs[2] = '{"w0000_p0", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
        vecs[3] = '{"w1111_p1", 4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1};
        vecs[4] = '{"w1000_p1", 4'b1000, 1'b1, 4'b1000, 4'b0001, 1'b0};
        vecs[5] = '{"w0110_p0", 4'b0110, 1'b0, 4'b0110, 4'b0110, 1'b0};

        reset = 1'b1; data_in = 1'b0; enable = 1'b0; set_all_ones = 1'b0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_data", 32'(bus0.out_data), 32'h0);
        check("rst_valid", 32'(bus0.out_valid), 32'h0);
        check("rst_overrun", 32'(bus0.overrun), 32'h0);
        check("rst_perr", 32'(bus0.parity_err), 32'h0);
        check("rst_shift", 32'(bus1.shift_out), 32'h0);

        // Back-to-back words, consumer always ready
        foreach (vecs[k]) begin
            send_word(vecs[k].bits, vecs[k].par);
            check({vecs[k].name, "_msb"}, 32'(bus0.out_data), 32'(vecs[k].exp_msb));
            check({vecs[k].name, "_lsb"}, 32'(bus1.out_data), 32'(vecs[k].exp_lsb));
            check({vecs[k].name, "_valid"}, 32'(bus0.out_valid), 32'h1);
            check({vecs[k].name, "_perr"}, 32'(bus0.parity_err), 32'(PAR_EN ? vecs[k].exp_perr : 1'b0));
            check({vecs[k].name, "_perr1"}, 32'(bus1.parity_err), 32'(PAR_EN ? vecs[k].exp_perr : 1'b0));
        end
        tick();

        // Stalled consumer: second word is dropped
        out_ready = 1'b0;
        send_word(4'b1010, 1'b0);
        check("stall_first_ovr", 32'(bus0.overrun), 32'h0);
        send_word(4'b0110, 1'b0);
        check("stall_data_msb", 32'(bus0.out_data), 32'hA);
        check("stall_data_lsb", 32'(bus1.out_data), 32'h5);
        check("stall_valid", 32'(bus0.out_valid), 32'h1);
        check("stall_overrun", 32'(bus0.overrun), 32'h1);
        out_ready = 1'b1;
        tick();
        check("drain_valid", 32'(bus0.out_valid), 32'h0);
        check("drain_data_hold", 32'(bus0.out_data), 32'hA);
        check("ovr_sticky", 32'(bus0.overrun), 32'h1);

        // Reset mid-word
        data_in = 1'b1; enable = 1'b1; tick(); tick(); tick();
        enable = 1'b0; reset = 1'b1; tick();
        reset = 1'b0;
        check("midrst_data", 32'(bus0.out_data), 32'h0);
        check("midrst_overrun", 32'(bus0.overrun), 32'h0);
        send_word(4'b1100, 1'b0);
        check("after_rst_msb", 32'(bus0.out_data), 32'hC);
        check("after_rst_lsb", 32'(bus1.out_data), 32'h3);
        check("after_rst_ovr", 32'(bus0.overrun), 32'h0);

        // Preset after a partial word
        data_in = 1'b1; enable = 1'b1; tick();
        data_in = 1'b0; tick();
        set_all_ones = 1'b1; tick();
        set_all_ones = 1'b0; enable = 1'b0;
        check("preset_shift_msb", 32'(bus0.shift_out), 32'hF);
        check("preset_shift_lsb", 32'(bus1.shift_out), 32'hF);
        send_word(4'b0010, 1'b1);
        check("preset_word_msb", 32'(bus0.out_data), 32'h2);
        check("preset_word_lsb", 32'(bus1.out_data), 32'h4);
        check("preset_word_perr", 32'(bus0.parity_err), 32'h0);

        // Preset right after a full set of data bits (PARITY state when enabled)
        send_bits(4'b1111);
        set_all_ones = 1'b1; enable = 1'b1; tick();
        set_all_ones = 1'b0; enable = 1'b0;
        send_word(4'b0101, 1'b0);
        check("par_preset_msb", 32'(bus0.out_data), 32'h5);
        check("par_preset_lsb", 32'(bus1.out_data), 32'hA);

        tick(); tick();
        check("sb_empty", 32'(sbq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sipo_stream.md
# sipo_stream

Parametrised serial-in/parallel-out deserialiser with bit counting, word framing and a valid/ready output handshake; successor to the fixed 4-bit SIPO. Collects WIDTH serial bits, MSB- or LSB-first, into a shift register. It then hands each completed word to a one-entry holding register for a downstream consumer. It sits between a serial front end and any word-oriented datapath, reporting lost words when the consumer stalls.

## Interface
- WIDTH, 8: bits per word, 2 or more.
- LSB_FIRST, 0: 0 = first received bit lands in MSB; 1 = first received bit lands in LSB.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit, sampled when enable=1.
- enable  input  1  bit-valid strobe; one bit consumed per clk edge with enable=1.
- set_all_ones  input  1  preset: shift register to all ones, bit counter to 0.
- shift_out  output  WIDTH  live shift-register contents.
- out_data  output  WIDTH  completed word in the holding register.
- out_valid  output  1  holding register holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data on an edge where out_valid=1.
- overrun  output  1  sticky; a completed word was dropped.
- parity_err  output  1  parity flag of the word in the holding register.

## Operation
- Reset: shift_out=0, out_data=0, out_valid=0, overrun=0, parity_err=0, bit counter=0, FSM=COLLECT.
- Shift, LSB_FIRST=0: shift_reg <= {shift_reg[WIDTH-2:0], data_in}.
- Shift, LSB_FIRST=1: shift_reg <= {data_in, shift_reg[WIDTH-1:1]}.
- Counter is $clog2(WIDTH+1) bits and counts accepted data bits 0..WIDTH-1.
- COLLECT state, enable=1: shift one bit and increment the counter.
- Word completion: on the WIDTH-th bit the counter wraps to 0. Without the parity feature, the word completes on that edge.
- Completion with the holding register free, or with out_ready=1 on the same edge: holding register <= the new word, including the bit shifted this edge. out_valid=1.
- Completion with out_valid=1 and out_ready=0: word dropped, holding register unchanged, overrun <= 1. overrun is cleared only by reset.
- Handshake: out_valid=1 and out_ready=1 with no completion: out_valid <= 0, out_data holds its last value.
- Priority: reset > set_all_ones > enable.
- set_all_ones: shift_reg <= all ones, counter <= 0, FSM <= COLLECT, data_in ignored. The holding register, out_valid and overrun are unaffected, and a partial word is discarded.
- enable=0: shift register and counter hold.

## Timing
- Last bit of a word sampled at edge N: out_valid and out_data are updated after edge N, so latency is one edge.
- Back-to-back words with no idle cycles are supported at one bit per clock with out_ready held high.
- out_data is stable while out_valid=1 and out_ready=0.
- Reset mid-word: the partial word is lost and the next accepted bit is bit 0 of a new word.

## Configuration
- SIPO_PARITY_EN defined:
  - After WIDTH data bits, the FSM enters PARITY.
  - The next enable=1 bit is the even-parity bit and is not shifted.
  - The word then completes, with parity_err = ^word ^ parity_bit, under the same handoff and overrun rules.
  - PARITY returns to COLLECT.
  - set_all_ones in PARITY returns the FSM to COLLECT.
- SIPO_PARITY_EN undefined: the FSM has only COLLECT and parity_err is tied to 0.

## Structure
- Package sipo_pkg holds:
  - the state enum (COLLECT, PARITY);
  - the counter-width function (clog2 of WIDTH+1);
  - the even-parity function.
- Sub-module sipo_bit_counter: WIDTH-parametrised counter with enable, clear and a wrap pulse.

## Test plan
- WIDTH=4, LSB_FIRST=0, out_ready=1, bits 1,0,1,1 -> out_data=4'b1011 and out_valid=1 one edge after the 4th bit.
- WIDTH=4, LSB_FIRST=1, same bits -> out_data=4'b1101.
- out_ready=0, two full words 1010 then 0110 -> out_data stays 1010, overrun=1 after the second word's last bit. Raising out_ready then clears out_valid.
- After 2 bits, pulse set_all_ones -> shift_out=1111 and counter=0. Bits 0,0,1,0 -> out_data=0010.
- Reset asserted after 3 bits, then bits 1,1,0,0 -> out_data=1100 and overrun=0.
- SIPO_PARITY_EN, WIDTH=4:
  - bits 1,0,1,1 with parity bit 1 -> parity_err=0;
  - repeated with parity bit 0 -> parity_err=1.
